// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
//   Front-end issuer for a registered ALU. Commands from an upstream master are
//   queued in a small FIFO. One command at a time is driven onto the ALU inputs.
//   The issuer waits ALU_LATENCY edges, captures the ALU result and returns it
//   with its opcode on a valid/ready response port. Responses are returned in
//   command order, and the result is passed through unmodified.
//
// Parameters
//   OPCODE_SIZE  opcode width (func / cmd_func / rsp_func)
//   DATA_SIZE    operand and result width
//   ALU_LATENCY  edges from stable ALU inputs to valid alu_dataOut (>= 1)
//   FIFO_DEPTH   command queue entries (power of two, >= 2)
//
// Ports
//   clk, rst_n                   rising-edge clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake; cmd_ready = rst_n & !full
//   cmd_func/cmd_data1/cmd_data2 command payload
//   alu_func/alu_data1/alu_data2 registered ALU inputs, held until next issue
//   alu_dataOut                  ALU result
//   rsp_valid/rsp_ready          response handshake (rsp_valid registered)
//   rsp_data/rsp_func            captured result and the opcode that made it
//   busy                         FSM not idle or queue not empty
//
// Configuration
//   ALU_ISSUE_STATS_EN  when defined, adds saturating counters:
//     stat_issued[15:0]  +1 per command issued to the ALU
//     stat_stall[15:0]   +1 per cycle with rsp_valid & !rsp_ready
// -----------------------------------------------------------------------------
module alu_cmd_issuer #(
  parameter int OPCODE_SIZE = 3,
  parameter int DATA_SIZE   = 8,
  parameter int ALU_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OPCODE_SIZE-1:0] cmd_func,
  input  logic [DATA_SIZE-1:0]   cmd_data1,
  input  logic [DATA_SIZE-1:0]   cmd_data2,
  output logic [OPCODE_SIZE-1:0] alu_func,
  output logic [DATA_SIZE-1:0]   alu_data1,
  output logic [DATA_SIZE-1:0]   alu_data2,
  input  logic [DATA_SIZE-1:0]   alu_dataOut,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_SIZE-1:0]   rsp_data,
  output logic [OPCODE_SIZE-1:0] rsp_func,
  output logic                   busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]            stat_issued,
  output logic [15:0]            stat_stall
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int CNT_W  = $clog2(ALU_LATENCY + 1);

  typedef struct packed {
    logic [OPCODE_SIZE-1:0] func;
    logic [DATA_SIZE-1:0]   data1;
    logic [DATA_SIZE-1:0]   data2;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  cmd_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full, fifo_empty;
  logic              push, pop, capture;
  logic [CNT_W-1:0]  cnt;
  cmd_t              head;

  assign fifo_full  = (fifo_count == FCNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign head       = fifo_mem[rd_ptr];

  // Ready depends on the registered full flag only, so a pop in the same
  // cycle never opens a slot for a push into a full queue.
  assign cmd_ready = rst_n & !fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (state != S_IDLE) | !fifo_empty;

  // NOTE: storage array has no reset; writes are gated by cmd_ready, which is
  // low during reset, and entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{func: cmd_func, data1: cmd_data1, data2: cmd_data2};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        // rsp_valid is always high in this state
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_func  <= '0;
      alu_data1 <= '0;
      alu_data2 <= '0;
      rsp_func  <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      if (pop) begin
        alu_func  <= head.func;
        alu_data1 <= head.data1;
        alu_data2 <= head.data2;
        rsp_func  <= head.func;
        cnt       <= CNT_W'(ALU_LATENCY);
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (capture) begin
        rsp_data  <= alu_dataOut;
        rsp_valid <= 1'b1;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (pop && stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
      if (rsp_valid && !rsp_ready && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_issuer
//   Self-checking bench for alu_cmd_issuer with a registered latency-1 ALU
//   model (000 add, 001 sub, 010 and, 011 or, 100 xor, others pass data1).
//   Define ALU_ISSUE_STATS_EN to also exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_func;
  logic [7:0] cmd_data1, cmd_data2;
  logic [2:0] alu_func;
  logic [7:0] alu_data1, alu_data2;
  logic [7:0] alu_dataOut;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_func;
  logic       busy;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_issued, stat_stall;
`endif

  always #5 clk = ~clk;

  alu_cmd_issuer #(
    .OPCODE_SIZE(3), .DATA_SIZE(8), .ALU_LATENCY(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_func(cmd_func), .cmd_data1(cmd_data1), .cmd_data2(cmd_data2),
    .alu_func(alu_func), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_dataOut(alu_dataOut),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_func(rsp_func),
    .busy(busy)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  // Registered ALU model, latency 1
  always_ff @(posedge clk) begin
    case (alu_func)
      3'b000:  alu_dataOut <= alu_data1 + alu_data2;
      3'b001:  alu_dataOut <= alu_data1 - alu_data2;
      3'b010:  alu_dataOut <= alu_data1 & alu_data2;
      3'b011:  alu_dataOut <= alu_data1 | alu_data2;
      3'b100:  alu_dataOut <= alu_data1 ^ alu_data2;
      default: alu_dataOut <= alu_data1;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Present a command and hold it until accepted (bounded).
  task automatic push(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_func  = f;
    cmd_data1 = a;
    cmd_data2 = b;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) timeout("push");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Wait for rsp_valid (bounded), compare, then step one edge.
  task automatic expect_rsp(input string name, input logic [7:0] d, input logic [2:0] f);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) timeout(name);
    else begin
      check({name, "_data"}, rsp_data, d);
      check({name, "_func"}, rsp_func, f);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0] func;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] exp_data;
    logic [2:0] exp_func;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3'b000, 8'h05, 8'h03, 8'h08, 3'b000};
    vecs[1] = '{3'b001, 8'h05, 8'h03, 8'h02, 3'b001};
    vecs[2] = '{3'b000, 8'hFF, 8'h01, 8'h00, 3'b000};
    vecs[3] = '{3'b001, 8'h00, 8'h01, 8'hFF, 3'b001};
    vecs[4] = '{3'b010, 8'hF0, 8'h3C, 8'h30, 3'b010};
    vecs[5] = '{3'b011, 8'hA0, 8'h0A, 8'hAA, 3'b011};
    vecs[6] = '{3'b100, 8'hAA, 8'hFF, 8'h55, 3'b100};

    // ---- Reset: pushes offered during reset must be ignored
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_func  = 3'b011;
    cmd_data1 = 8'h77;
    cmd_data2 = 8'h66;
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    repeat (10) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu", {alu_func, alu_data1, alu_data2}, 0);
    check("rst_rsp", {rsp_func, rsp_data}, 0);
    check("rst_busy", busy, 0);
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_no_push", busy, 0);
    check("rst_ready_after", cmd_ready, 1);

    // ---- Test 1: single op latency
    cmd_valid = 1'b1;
    cmd_func  = 3'b000;
    cmd_data1 = 8'd1;
    cmd_data2 = 8'd2;
    @(posedge clk); #1;           // push edge
    cmd_valid = 1'b0;
    check("t1_busy", busy, 1);
    @(posedge clk); #1;           // pop edge
    check("t1_alu", {alu_func, alu_data1, alu_data2}, {3'b000, 8'd1, 8'd2});
    check("t1_valid_early", rsp_valid, 0);
    @(posedge clk); #1;
    check("t1_valid_early2", rsp_valid, 0);
    @(posedge clk); #1;
    check("t1_valid", rsp_valid, 1);
    check("t1_data", rsp_data, 8'd3);
    check("t1_func", rsp_func, 3'b000);
    @(posedge clk); #1;
    check("t1_valid_clr", rsp_valid, 0);
    check("t1_idle", busy, 0);

    // ---- Test 2: back-pressure, 1 in flight + 4 queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_func  = 3'b000;
      cmd_data1 = 8'(i);
      cmd_data2 = 8'd10;
      check($sformatf("t2_ready%0d", i), cmd_ready, (i < 5));
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("t2_valid", rsp_valid, 1);
    check("t2_data", rsp_data, 8'd10);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("t2_hold_valid%0d", i), rsp_valid, 1);
      check($sformatf("t2_hold_data%0d", i), rsp_data, 8'd10);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) expect_rsp($sformatf("t2_rsp%0d", i), 8'(10 + i), 3'b000);
    repeat (4) @(posedge clk);
    #1;
    check("t2_no_sixth", rsp_valid, 0);
    check("t2_idle", busy, 0);

    // ---- Test 3/4: table vectors pushed back-to-back, checked in order
    fork
      begin
        for (int i = 0; i < 7; i++) push(vecs[i].func, vecs[i].d1, vecs[i].d2);
      end
      begin
        for (int j = 0; j < 7; j++)
          expect_rsp($sformatf("vec%0d", j), vecs[j].exp_data, vecs[j].exp_func);
      end
    join
    check("vec_idle", busy, 0);

    // ---- Test 4b: push and pop on the same edge with two queued
    rsp_ready = 1'b0;
    push(3'b000, 8'h11, 8'h01);
    begin
      int n = 0;
      while (!rsp_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("t4_a_data", rsp_data, 8'h12);
    push(3'b000, 8'h21, 8'h01);
    push(3'b000, 8'h31, 8'h01);
    rsp_ready = 1'b1;
    @(posedge clk); #1;           // A handshake, back to idle
    rsp_ready = 1'b0;
    check("t4_a_done", rsp_valid, 0);
    push(3'b000, 8'h41, 8'h01);   // accepted on the edge that pops B
    check("t4_pop_b", alu_data1, 8'h21);
    check("t4_cnt2_ready", cmd_ready, 1);
    push(3'b000, 8'h51, 8'h01);
    check("t4_cnt3_ready", cmd_ready, 1);
    push(3'b000, 8'h61, 8'h01);
    check("t4_cnt4_full", cmd_ready, 0);
    rsp_ready = 1'b1;
    expect_rsp("t4_b", 8'h22, 3'b000);
    expect_rsp("t4_c", 8'h32, 3'b000);
    expect_rsp("t4_d", 8'h42, 3'b000);
    expect_rsp("t4_e", 8'h52, 3'b000);
    expect_rsp("t4_f", 8'h62, 3'b000);

    // ---- Test 5: reset while waiting on the ALU with two queued
    push(3'b000, 8'd1, 8'd1);
    push(3'b000, 8'd2, 8'd2);
    push(3'b000, 8'd3, 8'd3);
    check("t5_wait", rsp_valid, 0);
    check("t5_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_ready_rst", cmd_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_busy_clr", busy, 0);
`ifdef ALU_ISSUE_STATS_EN
    check("t5_stat_issued", stat_issued, 0);
    check("t5_stat_stall", stat_stall, 0);
`endif
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (rsp_valid) seen++;
      end
      check("t5_no_rsp", seen, 0);
    end

`ifdef ALU_ISSUE_STATS_EN
    // ---- Test 6: statistics
    rsp_ready = 1'b0;
    push(3'b000, 8'd1, 8'd1);
    push(3'b001, 8'd5, 8'd1);
    push(3'b000, 8'd7, 8'd7);
    begin
      int n = 0;
      while (!rsp_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    repeat (4) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    expect_rsp("t6_a", 8'd2, 3'b000);
    expect_rsp("t6_b", 8'd4, 3'b001);
    expect_rsp("t6_c", 8'd14, 3'b000);
    check("t6_stat_issued", stat_issued, 3);
    check("t6_stat_stall", stat_stall, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
